// File: rtl/fp_pkg.sv
// Shared float-datapath definitions: operand classes, flag bit positions,
// divider FSM state encodings and format-dependent constants.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_e;

  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NORM = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_RND  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  function automatic int fp_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int fra_w);
    logic [63:0] ones_v;
    ones_v = (64'd1 << exp_w) - 64'd1;
    return (ones_v << fra_w) | (64'd1 << (fra_w - 32'sd1));
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Operand classifier: splits a packed float into class, sign, unbiased
// exponent and a significand with the leading one at bit FRA.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP = 5,
  parameter int FRA = 10,
  parameter int EW  = 11
) (
  input  logic [EXP+FRA:0]     x_i,
  output fp_class_e            cls_o,
  output logic                 sign_o,
  output logic signed [EW-1:0] exp_o,
  output logic [FRA:0]         sig_o
);

  localparam int LZW = $clog2(FRA + 1);
  localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP));

  logic [EXP-1:0] ef_s;
  logic [FRA-1:0] fr_s;
  logic [LZW-1:0] lz_s;

  assign ef_s   = x_i[EXP+FRA-1:FRA];
  assign fr_s   = x_i[FRA-1:0];
  assign sign_o = x_i[EXP+FRA];

  // Leading-zero count of the stored fraction (highest set bit wins)
  always_comb begin
    lz_s = LZW'(FRA);
    for (int i = 0; i < FRA; i++) begin
      lz_s = fr_s[i] ? LZW'(FRA - 1 - i) : lz_s;
    end
  end

  // Classify and left-normalise subnormals so every finite value reads 1.f * 2^e
  always_comb begin
    cls_o = CLS_NORM;
    exp_o = $signed({{(EW-EXP){1'b0}}, ef_s}) - BIAS_S;
    sig_o = {1'b1, fr_s};
    if (ef_s == {EXP{1'b1}}) begin
      cls_o = (fr_s == {FRA{1'b0}}) ? CLS_INF : CLS_NAN;
    end else if (ef_s == {EXP{1'b0}}) begin
      if (fr_s == {FRA{1'b0}}) begin
        cls_o = CLS_ZERO;
        exp_o = {EW{1'b0}};
        sig_o = {(FRA+1){1'b0}};
      end else begin
        cls_o = CLS_SUB;
        sig_o = {1'b0, fr_s} << (lz_s + LZW'(1));
        exp_o = -BIAS_S - $signed({{(EW-LZW){1'b0}}, lz_s});
      end
    end else begin
      cls_o = CLS_NORM;
    end
  end

endmodule

// File: rtl/tdiv_iter.sv
// Iterative radix-2 restoring floating-point divider behind AXI-stream
// handshakes: one quotient bit per cycle, fixed latency, IEEE-style flags.
module tdiv_iter
  import fp_pkg::*;
#(
  parameter int EXP      = 5,
  parameter int FRA      = 10,
  parameter int RND_MODE = 0
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [EXP+FRA:0]   s_axis_a_tdata,
  input  logic               s_axis_a_tvalid,
  output logic               s_axis_a_tready,
  input  logic [EXP+FRA:0]   s_axis_b_tdata,
  input  logic               s_axis_b_tvalid,
  output logic               s_axis_b_tready,
  output logic [EXP+FRA:0]   m_axis_tdata,
  output logic [4:0]         m_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  localparam int W  = EXP + FRA + 1;
  localparam int EW = EXP + $clog2(FRA + 1) + 2;
  localparam int MW = FRA + 3;
  localparam int CW = $clog2(FRA + 3);
  localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP, FRA));
  localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP));
  localparam logic [EW-1:0]        EMAX   = EW'((32'sd1 <<< EXP) - 32'sd1);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [FRA+1:0]       rem_q, rem_d;
  logic [FRA:0]         bsig_q, bsig_d;
  logic [MW-1:0]        quo_q, quo_d;
  logic                 spec_q, spec_d;
  logic [W-1:0]         spec_data_q, spec_data_d;
  logic [4:0]           spec_flags_q, spec_flags_d;
  logic [W-1:0]         tdata_q, tdata_d;
  logic [4:0]           tuser_q, tuser_d;
  logic                 tvalid_q, tvalid_d;

  fp_class_e            cls_a_s, cls_b_s;
  logic                 sign_a_s, sign_b_s, sign_x_s;
  logic signed [EW-1:0] ea_s, eb_s;
  logic [FRA:0]         sa_s, sb_s;
  logic                 accept_s, ge_s;
  logic [FRA+1:0]       diff_s;

  fp_unpack #(.EXP(EXP), .FRA(FRA), .EW(EW)) u_unpack_a (
    .x_i(a_q), .cls_o(cls_a_s), .sign_o(sign_a_s), .exp_o(ea_s), .sig_o(sa_s)
  );
  fp_unpack #(.EXP(EXP), .FRA(FRA), .EW(EW)) u_unpack_b (
    .x_i(b_q), .cls_o(cls_b_s), .sign_o(sign_b_s), .exp_o(eb_s), .sig_o(sb_s)
  );

  assign s_axis_a_tready = (state_q == ST_IDLE) && !areset;
  assign s_axis_b_tready = (state_q == ST_IDLE) && !areset;
  assign accept_s = s_axis_a_tready && s_axis_a_tvalid && s_axis_b_tvalid;
  assign sign_x_s = sign_a_s ^ sign_b_s;
  assign ge_s     = (rem_q >= {1'b0, bsig_q});
  assign diff_s   = rem_q - {1'b0, bsig_q};
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;

  logic [MW-1:0]        nm_s, msh_s, lost_mask_s;
  logic signed [EW-1:0] ne_s, be_s;
  logic [EW-1:0]        sh_s, ef_s;
  logic                 tiny_s, g_s, r_s, st_s, inexact_s, inc_s, ovf_s;
  logic [EW+FRA-1:0]    sum_s;
  logic [W-1:0]         rdata_s;
  logic [4:0]           rflags_s;

  // Post-divide normalise, denormalise when tiny, round and detect overflow
  always_comb begin
    if (quo_q[MW-1]) begin
      nm_s = quo_q;
      ne_s = exp_q;
    end else begin
      nm_s = {quo_q[MW-2:0], 1'b0};
      ne_s = exp_q - {{(EW-1){1'b0}}, 1'b1};
    end
    be_s   = ne_s + BIAS_S;
    tiny_s = be_s[EW-1] || (be_s == {EW{1'b0}});
    sh_s   = {{(EW-1){1'b0}}, 1'b1} - be_s;
    if (tiny_s) begin
      lost_mask_s = ~({MW{1'b1}} << sh_s);
      msh_s       = nm_s >> sh_s;
      ef_s        = {EW{1'b0}};
    end else begin
      lost_mask_s = {MW{1'b0}};
      msh_s       = nm_s;
      ef_s        = be_s;
    end
    g_s       = msh_s[1];
    r_s       = msh_s[0];
    st_s      = (|rem_q) | (|(nm_s & lost_mask_s));
    inexact_s = g_s | r_s | st_s;
    inc_s     = (RND_MODE == 0) ? (g_s & (r_s | st_s | msh_s[2])) : 1'b0;
    // Exponent and fraction added as one word so a carry renormalises for free
    sum_s     = {ef_s, msh_s[FRA+1:2]} + {{(EW+FRA-1){1'b0}}, inc_s};
    ovf_s     = (sum_s[EW+FRA-1:FRA] >= EMAX);
    rflags_s  = 5'b00000;
    if (ovf_s) begin
      rdata_s = (RND_MODE == 0) ? {sign_q, {EXP{1'b1}}, {FRA{1'b0}}}
                                : {sign_q, {(EXP-1){1'b1}}, 1'b0, {FRA{1'b1}}};
      rflags_s[FLG_OVERFLOW] = 1'b1;
      rflags_s[FLG_INEXACT]  = 1'b1;
    end else begin
      rdata_s = {sign_q, sum_s[EXP+FRA-1:0]};
      rflags_s[FLG_UNDERFLOW] = tiny_s & inexact_s;
      rflags_s[FLG_INEXACT]   = inexact_s;
    end
  end

  // Control FSM and iterative datapath next-state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    rem_d        = rem_q;
    bsig_d       = bsig_q;
    quo_d        = quo_q;
    spec_d       = spec_q;
    spec_data_d  = spec_data_q;
    spec_flags_d = spec_flags_q;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    tvalid_d     = tvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = s_axis_a_tdata;
          b_d     = s_axis_b_tdata;
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        sign_d       = sign_x_s;
        exp_d        = ea_s - eb_s;
        rem_d        = {1'b0, sa_s};
        bsig_d       = sb_s;
        quo_d        = {MW{1'b0}};
        cnt_d        = {CW{1'b0}};
        spec_d       = 1'b1;
        spec_flags_d = 5'b00000;
        spec_data_d  = QNAN;
        if (cls_a_s == CLS_NAN || cls_b_s == CLS_NAN) begin
          spec_data_d = QNAN;
        end else if ((cls_a_s == CLS_ZERO && cls_b_s == CLS_ZERO) ||
                     (cls_a_s == CLS_INF && cls_b_s == CLS_INF)) begin
          spec_flags_d[FLG_INVALID] = 1'b1;
        end else if (cls_b_s == CLS_ZERO) begin
          spec_data_d = {sign_x_s, {EXP{1'b1}}, {FRA{1'b0}}};
          spec_flags_d[FLG_DIVZERO] = 1'b1;
        end else if (cls_a_s == CLS_INF) begin
          spec_data_d = {sign_x_s, {EXP{1'b1}}, {FRA{1'b0}}};
        end else if (cls_b_s == CLS_INF || cls_a_s == CLS_ZERO) begin
          spec_data_d = {sign_x_s, {(W-1){1'b0}}};
        end else begin
          spec_d = 1'b0;
        end
        state_d = ST_DIV;
      end
      ST_DIV: begin
        // Specials still run the full count so latency never varies
        if (ge_s) begin
          quo_d = {quo_q[MW-2:0], 1'b1};
          rem_d = {diff_s[FRA:0], 1'b0};
        end else begin
          quo_d = {quo_q[MW-2:0], 1'b0};
          rem_d = {rem_q[FRA:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRA + 2)) begin
          state_d = ST_RND;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_RND: begin
        if (spec_q) begin
          tdata_d = spec_data_q;
          tuser_d = spec_flags_q;
        end else begin
          tdata_d = rdata_s;
          tuser_d = rflags_s;
        end
        tvalid_d = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_OUT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      sign_q       <= 1'b0;
      exp_q        <= {EW{1'b0}};
      rem_q        <= {(FRA+2){1'b0}};
      bsig_q       <= {(FRA+1){1'b0}};
      quo_q        <= {MW{1'b0}};
      spec_q       <= 1'b0;
      spec_data_q  <= {W{1'b0}};
      spec_flags_q <= 5'b00000;
      tdata_q      <= {W{1'b0}};
      tuser_q      <= 5'b00000;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      rem_q        <= rem_d;
      bsig_q       <= bsig_d;
      quo_q        <= quo_d;
      spec_q       <= spec_d;
      spec_data_q  <= spec_data_d;
      spec_flags_q <= spec_flags_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tvalid_q     <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_tdiv_iter.sv
// Directed bench for tdiv_iter (half precision, round-to-nearest-even):
// hand-computed quotients, flags, latency and handshake corner cases.
module tb_tdiv_iter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid, a_tready, b_tready;
  logic [15:0] m_tdata;
  logic [4:0]  m_tuser;
  logic        m_tvalid, m_tready;

  int n_checks = 0;
  int n_errors = 0;

  tdiv_iter #(.EXP(5), .FRA(10), .RND_MODE(0)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_a_tdata  (a_tdata),
    .s_axis_a_tvalid (a_tvalid),
    .s_axis_a_tready (a_tready),
    .s_axis_b_tdata  (b_tdata),
    .s_axis_b_tvalid (b_tvalid),
    .s_axis_b_tready (b_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tuser    (m_tuser),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    @(negedge aclk);
    while (!a_tready && waited < 40) begin
      @(negedge aclk);
      waited++;
    end
    if (waited >= 40) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge aclk);
      #1;
      if (m_tvalid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [4:0] f);
    int lat;
    wait_ready(tag);
    a_tdata = a; b_tdata = b; a_tvalid = 1'b1; b_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    wait_result(lat);
    check({tag, "_data"}, m_tdata, q);
    check({tag, "_flags"}, m_tuser, f);
    check({tag, "_lat"}, lat, 32'd15);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad, rbad;
    logic [15:0] d0;
    logic [4:0]  u0;
    areset = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
    a_tdata = 16'h0000; b_tdata = 16'h0000;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_tvalid, 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tuser", m_tuser, 32'd0);
    check("rst_rdy_in_reset", a_tready, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst_rdy_a", a_tready, 32'd1);
    check("rst_rdy_b", b_tready, 32'd1);

    run_vec("normal",  16'h388F, 16'h3266, 16'h41B3, 5'h01);
    run_vec("third",   16'h3C00, 16'h4200, 16'h3555, 5'h01);
    run_vec("exact",   16'h4600, 16'h4200, 16'h4000, 5'h00);
    run_vec("neg",     16'hC400, 16'h4000, 16'hC000, 5'h00);
    run_vec("subsub",  16'h03AC, 16'h0011, 16'h52E9, 5'h01);
    run_vec("subexact",16'h0400, 16'h4000, 16'h0200, 5'h00);
    run_vec("divzero", 16'h3C00, 16'h0000, 16'h7C00, 5'h08);
    run_vec("zz",      16'h0000, 16'h0000, 16'h7E00, 5'h10);
    run_vec("inf_fin", 16'h7C00, 16'h4000, 16'h7C00, 5'h00);
    run_vec("fin_inf", 16'hBC00, 16'h7C00, 16'h8000, 5'h00);
    run_vec("nan_in",  16'h7E01, 16'h3C00, 16'h7E00, 5'h00);
    run_vec("ovf",     16'h7BFF, 16'h0001, 16'h7C00, 5'h05);
    run_vec("unf_tie", 16'h0001, 16'h4000, 16'h0000, 5'h03);
    run_vec("unf_odd", 16'h0003, 16'h4000, 16'h0002, 5'h03);
    run_vec("sub2min", 16'h07FF, 16'h4000, 16'h0400, 5'h03);

    // Only one operand valid: nothing may be consumed
    wait_ready("join");
    a_tdata = 16'h3C00; a_tvalid = 1'b1; b_tvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge aclk);
      #1;
      if (i == 9) a_tvalid = 1'b0;
      if (!a_tready || m_tvalid) bad++;
    end
    check("join_no_accept", bad, 32'd0);

    // Downstream stall: output held, inputs blocked
    m_tready = 1'b0;
    wait_ready("stall");
    a_tdata = 16'h4600; b_tdata = 16'h4200; a_tvalid = 1'b1; b_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    wait_result(lat);
    check("stall_data", m_tdata, 32'h4000);
    check("stall_lat", lat, 32'd15);
    d0 = m_tdata; u0 = m_tuser; bad = 0; rbad = 0;
    repeat (20) begin
      @(posedge aclk);
      #1;
      if (m_tdata !== d0 || m_tuser !== u0 || !m_tvalid) bad++;
      if (a_tready || b_tready) rbad++;
    end
    check("stall_hold", bad, 32'd0);
    check("stall_rdy", rbad, 32'd0);

    // New operands presented on the consuming edge wait for the next IDLE cycle
    @(negedge aclk);
    m_tready = 1'b1;
    a_tdata = 16'hC400; b_tdata = 16'h4000; a_tvalid = 1'b1; b_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    check("reacc_tvalid", m_tvalid, 32'd0);
    check("reacc_idle", a_tready, 32'd1);
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    wait_result(lat);
    check("reacc_data", m_tdata, 32'hC000);
    check("reacc_flags", m_tuser, 32'h00);
    check("reacc_lat", lat, 32'd15);

    // Reset in the middle of DIV aborts the operation silently
    wait_ready("mid_rst");
    a_tdata = 16'h388F; b_tdata = 16'h3266; a_tvalid = 1'b1; b_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("midrst_tvalid", m_tvalid, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("midrst_rdy_a", a_tready, 32'd1);
    check("midrst_rdy_b", b_tready, 32'd1);
    bad = 0;
    repeat (25) begin
      @(posedge aclk);
      #1;
      if (m_tvalid) bad++;
    end
    check("midrst_no_stale", bad, 32'd0);
    run_vec("post_rst", 16'h3C00, 16'h4200, 16'h3555, 5'h01);

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
